// File: rtl/reg_file_sb_pkg.sv
// Processor-wide register file constants and types.
// Shared by the register file, its read ports and the decode stage.
package reg_file_sb_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 16;
    localparam int AW    = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    reg_addr_t;

endpackage

// File: rtl/reg_read_port.sv
// One synchronous read port: word select with same-edge write bypass,
// plus the post-update busy flag of the addressed register.
module reg_read_port
    import reg_file_sb_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic [NREGS-1:0]            pending_nxt,
    input  reg_addr_t                   rd_addr,
    input  logic                        wr_en,
    input  reg_addr_t                   wr_addr,
    input  word_t                       wr_data,
    output word_t                       rd_data,
    output logic                        rd_busy
);

    word_t sel_data;
    logic  sel_busy;

    // A write landing on the same edge must be seen, not the stale array value.
    always_comb begin
        sel_data = regs[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            sel_data = wr_data;
        end
        sel_busy = pending_nxt[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else begin
            rd_data <= sel_data;
            rd_busy <= sel_busy;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// 16x16 register file with two bypassed read ports and a one-deep-per-register
// write scoreboard used by decode for RAW hazard detection.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  word_t            wr_data,
    input  logic             rsv_en,
    input  reg_addr_t        rsv_addr,
    input  reg_addr_t        rs_addr,
    input  reg_addr_t        rt_addr,
    output word_t            rs_data,
    output word_t            rt_data,
    output logic             rs_busy,
    output logic             rt_busy,
    output logic [NREGS-1:0] busy_vec,
    output logic             rsv_conflict
);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [NREGS-1:0]            pending;
    logic [NREGS-1:0]            pending_nxt;
    logic                        conflict_nxt;

    // Reserve is applied after the write-clear so a same-edge reservation wins.
    always_comb begin
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            pending_nxt[rsv_addr] = 1'b1;
        end
        conflict_nxt = rsv_en && pending[rsv_addr] &&
                       !(wr_en && (wr_addr == rsv_addr));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs         <= '0;
            pending      <= '0;
            rsv_conflict <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            pending      <= pending_nxt;
            rsv_conflict <= conflict_nxt;
        end
    end

    assign busy_vec = pending;

    reg_read_port u_port_rs (
        .clk         (clk),
        .reset       (reset),
        .regs        (regs),
        .pending_nxt (pending_nxt),
        .rd_addr     (rs_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_data     (rs_data),
        .rd_busy     (rs_busy)
    );

    reg_read_port u_port_rt (
        .clk         (clk),
        .reset       (reset),
        .regs        (regs),
        .pending_nxt (pending_nxt),
        .rd_addr     (rt_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_data     (rt_data),
        .rd_busy     (rt_busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus a randomized
// run against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        rs_busy;
    logic        rt_busy;
    logic [15:0] busy_vec;
    logic        rsv_conflict;

    int total = 0;
    int bad   = 0;

    // Behavioural model: architectural contents and outstanding-write flags.
    logic [15:0] m_regs [16];
    logic        m_pend [16];
    logic [15:0] e_rs, e_rt;
    logic        e_rsb, e_rtb, e_conf;
    logic [15:0] exp_q [$];

    reg_file_sb dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .busy_vec     (busy_vec),
        .rsv_conflict (rsv_conflict)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 16'h0;
            m_pend[i] = 1'b0;
        end
        e_rs = 0; e_rt = 0; e_rsb = 0; e_rtb = 0; e_conf = 0;
    endtask

    function automatic logic [15:0] model_busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // ---------------- driver ----------------
    // Presents one cycle of inputs, lets the edge happen, then advances the model.
    task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic re, input logic [3:0] ra,
                        input logic [3:0] sa, input logic [3:0] ta);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rs_addr = sa; rt_addr = ta;
        @(posedge clk);
        #1;
        e_conf = re && m_pend[ra] && !(we && wa == ra);
        e_rs = (we && wa == sa) ? wd : m_regs[sa];
        e_rt = (we && wa == ta) ? wd : m_regs[ta];
        if (we) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
        end
        if (re) m_pend[ra] = 1'b1;
        e_rsb = m_pend[sa];
        e_rtb = m_pend[ta];
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] ta);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, sa, ta);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
        rs_addr = 0; rt_addr = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rs_data !== 16'h0 || rt_data !== 16'h0 || busy_vec !== 16'h0 || rsv_conflict !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rs=%h rt=%h busy=%h conf=%b want all 0", rs_data, rt_data, busy_vec, rsv_conflict);
        end
        reset = 1'b0;
        step(1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd6, 4'd5, 4'd5);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 4'd5, 4'd6);
        total++;
        if (rs_data !== 16'hBEEF || busy_vec !== 16'h0040 || rsv_conflict !== 1'b1) begin
            bad++;
            $display("FAIL reset_prefill: rs=%h busy=%h conf=%b want BEEF 0040 1", rs_data, busy_vec, rsv_conflict);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (rs_data !== 16'h0 || rt_data !== 16'h0 || busy_vec !== 16'h0 || rsv_conflict !== 1'b0 || rt_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: rs=%h rt=%h busy=%h conf=%b rtb=%b want all 0", rs_data, rt_data, busy_vec, rsv_conflict, rt_busy);
        end
        wr_en = 1; wr_addr = 4'd5; wr_data = 16'h1111; rsv_en = 1; rsv_addr = 4'd5;
        @(posedge clk);
        #1;
        total++;
        if (rs_data !== 16'h0 || busy_vec !== 16'h0) begin
            bad++;
            $display("FAIL reset_hold: rs=%h busy=%h want 0 0", rs_data, busy_vec);
        end
        reset = 1'b0;
        model_clear();
        idle(4'd5, 4'd5);
        total++;
        if (rs_data !== 16'h0000 || rt_data !== 16'h0000 || busy_vec !== 16'h0) begin
            bad++;
            $display("FAIL reset_r5: rs=%h rt=%h busy=%h want 0000 0000 0000", rs_data, rt_data, busy_vec);
        end
    endtask

    task automatic test_basic_rw();
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd0, 4'd0);
        idle(4'd3, 4'd3);
        total++;
        if (rs_data !== 16'h1234 || rt_data !== 16'h1234) begin
            bad++;
            $display("FAIL basic_rw: rs=%h rt=%h want 1234 1234", rs_data, rt_data);
        end
        step(1'b1, 4'd15, 16'hF00D, 1'b0, 4'd0, 4'd0, 4'd0);
        idle(4'd15, 4'd0);
        total++;
        if (rs_data !== 16'hF00D || rt_data !== 16'h0000) begin
            bad++;
            $display("FAIL basic_r15_r0: rs=%h rt=%h want F00D 0000", rs_data, rt_data);
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 4'd7, 16'h0001, 1'b0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 4'd7, 4'd3);
        total++;
        if (rs_data !== 16'hA5A5 || rt_data !== 16'h1234) begin
            bad++;
            $display("FAIL bypass: rs=%h rt=%h want A5A5 1234", rs_data, rt_data);
        end
    endtask

    task automatic test_scoreboard();
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd0, 4'd0);
        total++;
        if (busy_vec[9] !== 1'b1) begin
            bad++;
            $display("FAIL sb_reserve: busy_vec[9]=%b want 1", busy_vec[9]);
        end
        idle(4'd9, 4'd8);
        total++;
        if (rs_busy !== 1'b1 || rt_busy !== 1'b0) begin
            bad++;
            $display("FAIL sb_rs_busy: rs_busy=%b rt_busy=%b want 1 0", rs_busy, rt_busy);
        end
        step(1'b1, 4'd9, 16'h00FF, 1'b0, 4'd0, 4'd9, 4'd9);
        total++;
        if (busy_vec[9] !== 1'b0 || rs_busy !== 1'b0 || rs_data !== 16'h00FF || rt_data !== 16'h00FF) begin
            bad++;
            $display("FAIL sb_writeback: busy9=%b rs_busy=%b rs=%h rt=%h want 0 0 00FF 00FF", busy_vec[9], rs_busy, rs_data, rt_data);
        end
    endtask

    task automatic test_simul_wr_rsv();
        step(1'b1, 4'd2, 16'h5A5A, 1'b1, 4'd2, 4'd2, 4'd0);
        total++;
        if (busy_vec[2] !== 1'b1 || rsv_conflict !== 1'b0 || rs_data !== 16'h5A5A || rs_busy !== 1'b1) begin
            bad++;
            $display("FAIL simul: busy2=%b conf=%b rs=%h rs_busy=%b want 1 0 5A5A 1", busy_vec[2], rsv_conflict, rs_data, rs_busy);
        end
        // r2 is now pending; a write+reserve pair on it is still not a conflict.
        step(1'b1, 4'd2, 16'h6B6B, 1'b1, 4'd2, 4'd0, 4'd0);
        idle(4'd2, 4'd2);
        total++;
        if (busy_vec[2] !== 1'b1 || rsv_conflict !== 1'b0 || rt_data !== 16'h6B6B) begin
            bad++;
            $display("FAIL simul_pending: busy2=%b conf=%b rt=%h want 1 0 6B6B", busy_vec[2], rsv_conflict, rt_data);
        end
    endtask

    task automatic test_double_reserve();
        logic [2:0] seen;
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd0, 4'd0);
        seen[0] = rsv_conflict;
        idle(4'd0, 4'd0);
        seen[1] = rsv_conflict;
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd0, 4'd0);
        seen[2] = rsv_conflict;
        total++;
        if (seen !== 3'b100 || busy_vec[4] !== 1'b1) begin
            bad++;
            $display("FAIL double_rsv: conf_seq=%b busy4=%b want 100 1", seen, busy_vec[4]);
        end
        idle(4'd4, 4'd0);
        total++;
        if (rsv_conflict !== 1'b0 || busy_vec[4] !== 1'b1 || rs_busy !== 1'b1) begin
            bad++;
            $display("FAIL double_rsv_after: conf=%b busy4=%b rs_busy=%b want 0 1 1", rsv_conflict, busy_vec[4], rs_busy);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_rs;
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            exp_q.push_back(e_rs);
            exp_rs = exp_q.pop_front();
            total++;
            if (rs_data !== exp_rs || rt_data !== e_rt || rs_busy !== e_rsb || rt_busy !== e_rtb ||
                rsv_conflict !== e_conf || busy_vec !== model_busy_vec()) begin
                bad++;
                $display("FAIL random[%0d]: rs=%h/%h rt=%h/%h rsb=%b/%b rtb=%b/%b conf=%b/%b busy=%h/%h (got/want)",
                         n, rs_data, exp_rs, rt_data, e_rt, rs_busy, e_rsb, rt_busy, e_rtb,
                         rsv_conflict, e_conf, busy_vec, model_busy_vec());
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic_rw();
        test_bypass();
        test_scoreboard();
        test_simul_wr_rsv();
        test_double_reserve();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
